// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants, types and decode helpers for the 7-segment scan decoder.
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  // Segment patterns in {g,f,e,d,c,b,a} order (bit0 = a), active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Decode result: ok = recognised glyph, blank = all segments off.
  typedef struct packed {
    logic       ok;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  // Map a segment pattern back to its hex nibble.
  function automatic seg_dec_t seg7_to_hex(input logic [6:0] pat);
    seg_dec_t res;
    res = '{ok: 1'b0, blank: 1'b0, nibble: 4'h0};
    case (pat)
      SEG_0:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'h0};
      SEG_1:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'h1};
      SEG_2:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'h2};
      SEG_3:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'h3};
      SEG_4:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'h4};
      SEG_5:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'h5};
      SEG_6:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'h6};
      SEG_7:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'h7};
      SEG_8:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'h8};
      SEG_9:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'h9};
      SEG_A:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'hA};
      SEG_B:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'hB};
      SEG_C:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'hC};
      SEG_D:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'hD};
      SEG_E:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'hE};
      SEG_F:     res = '{ok: 1'b1, blank: 1'b0, nibble: 4'hF};
      SEG_BLANK: res = '{ok: 1'b0, blank: 1'b1, nibble: 4'h0};
      default:   res = '{ok: 1'b0, blank: 1'b0, nibble: 4'h0};
    endcase
    return res;
  endfunction

  // True when exactly one digit select line is set.
  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != {NUM_DIGITS{1'b0}}) &&
           ((v & (v - {{(NUM_DIGITS-1){1'b0}}, 1'b1})) == {NUM_DIGITS{1'b0}});
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] res;
    if (v == 8'hFF) begin
      res = v;
    end else begin
      res = v + 8'h01;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display bus seen by the decoder plus the decoded image it publishes.
interface seg_scan_decoder_if;
  import seg_pkg::*;

  logic [NUM_DIGITS-1:0]   digit;
  logic [7:0]              seg;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   valid;
  logic                    frame_done;
  logic                    stale;
  logic [7:0]              err_cnt;

  // Display side: drives the scan lines, observes the decoded image.
  modport master (
    output digit, seg,
    input  value, dp, valid, frame_done, stale, err_cnt
  );

  // Decoder side.
  modport slave (
    input  digit, seg,
    output value, dp, valid, frame_done, stale, err_cnt
  );
endinterface

// File: rtl/seg_scan_decoder_in_filter.sv
// Input conditioning: polarity normalize, 2-flop sync, stability filter.
module seg_in_filter
  import seg_pkg::*;
#(
  parameter int STABLE_CYC    = 4,
  parameter int DIGIT_ACT_LOW = 0,
  parameter int SEG_ACT_LOW   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_DIGITS-1:0] digit,
  input  logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] s_digit,
  output logic [7:0]            s_seg,
  output logic                  accept
);

  localparam int SW    = NUM_DIGITS + 8;
  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
  // Accept is seen one cycle before cnt lands on STABLE_CYC-1.
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYC - 2);

  logic [NUM_DIGITS-1:0] norm_digit;
  logic [7:0]            norm_seg;
  logic [SW-1:0]         sync1;
  logic [SW-1:0]         sync2;
  logic [SW-1:0]         prev;
  logic [CNT_W-1:0]      cnt;
  logic                  same;

  // Bring both buses to active-high before synchronizing.
  always_comb begin
    if (DIGIT_ACT_LOW != 0) begin
      norm_digit = ~digit;
    end else begin
      norm_digit = digit;
    end
    if (SEG_ACT_LOW != 0) begin
      norm_seg = ~seg;
    end else begin
      norm_seg = seg;
    end
  end

  // Two-flop synchronizer followed by the previous-sample register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= {SW{1'b0}};
      sync2 <= {SW{1'b0}};
      prev  <= {SW{1'b0}};
    end else begin
      sync1 <= {norm_digit, norm_seg};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign same = (sync2 == prev);

  // Stability counter: restarts on any change, saturates once accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (!same) begin
      cnt <= {CNT_W{1'b0}};
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign accept  = same && (cnt == CNT_ACC);
  assign s_digit = sync2[SW-1:8];
  assign s_seg   = sync2[7:0];

endmodule

// File: rtl/seg_scan_decoder.sv
// Passive 6-digit 7-segment scan monitor: rebuilds the displayed image.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYC    = 4,
  parameter int TIMEOUT_CYC   = 1_000_000,
  parameter int DIGIT_ACT_LOW = 0,
  parameter int SEG_ACT_LOW   = 0
) (
  input logic              clk,
  input logic              rst,
  seg_scan_decoder_if.slave bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = {NUM_DIGITS{1'b1}};

  logic [NUM_DIGITS-1:0]   s_digit;
  logic [7:0]              s_seg;
  logic                    accept;

  logic [4*NUM_DIGITS-1:0] img_value;
  logic [NUM_DIGITS-1:0]   img_dp;
  logic [NUM_DIGITS-1:0]   img_valid;
  logic [NUM_DIGITS-1:0]   seen;
  logic                    frame_pulse;
  logic                    stale_flag;
  logic [7:0]              errs;
  logic [TMR_W-1:0]        timer;

  seg_dec_t                dec;
  logic                    onehot;
  logic                    multi;
  logic [NUM_DIGITS-1:0]   seen_next;
  logic                    timer_hit;

  seg_in_filter #(
    .STABLE_CYC    (STABLE_CYC),
    .DIGIT_ACT_LOW (DIGIT_ACT_LOW),
    .SEG_ACT_LOW   (SEG_ACT_LOW)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .digit   (bus.digit),
    .seg     (bus.seg),
    .s_digit (s_digit),
    .s_seg   (s_seg),
    .accept  (accept)
  );

  // Classify the accepted sample and precompute frame / timeout conditions.
  always_comb begin
    dec       = seg7_to_hex(s_seg[6:0]);
    onehot    = is_onehot(s_digit);
    multi     = (s_digit != {NUM_DIGITS{1'b0}}) && !onehot;
    seen_next = seen | s_digit;
    timer_hit = !stale_flag && (timer == TMR_LAST);
  end

  // Image, frame mask, idle timer and error counter; accept beats timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_value   <= {(4*NUM_DIGITS){1'b0}};
      img_dp      <= {NUM_DIGITS{1'b0}};
      img_valid   <= {NUM_DIGITS{1'b0}};
      seen        <= {NUM_DIGITS{1'b0}};
      frame_pulse <= 1'b0;
      stale_flag  <= 1'b0;
      errs        <= 8'h00;
      timer       <= {TMR_W{1'b0}};
    end else begin
      frame_pulse <= 1'b0;
      if (accept && onehot) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (s_digit[i]) begin
            if (dec.ok) begin
              img_value[4*i +: 4] <= dec.nibble;
              img_valid[i]        <= 1'b1;
            end else begin
              img_valid[i]        <= 1'b0;
            end
            img_dp[i] <= s_seg[7];
          end
        end
        if (!dec.ok && !dec.blank) begin
          errs <= sat_inc8(errs);
        end
        if (seen_next == ALL_SEEN) begin
          frame_pulse <= 1'b1;
          seen        <= {NUM_DIGITS{1'b0}};
        end else begin
          seen        <= seen_next;
        end
        stale_flag <= 1'b0;
        timer      <= {TMR_W{1'b0}};
      end else if (accept && multi) begin
        errs  <= sat_inc8(errs);
        timer <= {TMR_W{1'b0}};
      end else if (timer_hit) begin
        stale_flag <= 1'b1;
        img_valid  <= {NUM_DIGITS{1'b0}};
        img_dp     <= {NUM_DIGITS{1'b0}};
        seen       <= {NUM_DIGITS{1'b0}};
        timer      <= timer + {{(TMR_W-1){1'b0}}, 1'b1};
      end else if (!stale_flag) begin
        timer <= timer + {{(TMR_W-1){1'b0}}, 1'b1};
      end else begin
        timer <= timer;
      end
    end
  end

  assign bus.value      = img_value;
  assign bus.dp         = img_dp;
  assign bus.valid      = img_valid;
  assign bus.frame_done = frame_pulse;
  assign bus.stale      = stale_flag;
  assign bus.err_cnt    = errs;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder.
module tb_seg_scan_decoder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   fd_cnt;
  int   fd_base;

  seg_scan_decoder_if bus();

  seg_scan_decoder #(
    .STABLE_CYC    (4),
    .TIMEOUT_CYC   (50),
    .DIGIT_ACT_LOW (0),
    .SEG_ACT_LOW   (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_done pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.frame_done) fd_cnt = fd_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [5:0] d, input logic [7:0] s, input int n);
    bus.digit = d;
    bus.seg   = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input int n, input logic [7:0] s);
    hold(6'd1 << n, s, 8);
    hold(6'd0, 8'h00, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; fd_cnt = 0; fd_base = 0;
    rst = 1'b1;
    bus.digit = 6'd0;
    bus.seg   = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_val("rst_value", 32'(bus.value), 32'h0);
    check_val("rst_dp",    32'(bus.dp), 32'h0);
    check_val("rst_valid", 32'(bus.valid), 32'h0);
    check_val("rst_fd",    32'(bus.frame_done), 32'h0);
    check_val("rst_stale", 32'(bus.stale), 32'h0);
    check_val("rst_err",   32'(bus.err_cnt), 32'h0);
    @(posedge clk); #1;

    // Scan "123456"
    scan(0, 8'h06); scan(1, 8'h5B); scan(2, 8'h4F); scan(3, 8'h66); scan(4, 8'h6D);
    check_val("t1_fd_early", 32'(fd_cnt), 32'd0);
    scan(5, 8'h7D);
    check_val("t1_fd",    32'(fd_cnt), 32'd1);
    check_val("t1_value", 32'(bus.value), 32'h654321);
    check_val("t1_valid", 32'(bus.valid), 32'h3F);
    check_val("t1_err",   32'(bus.err_cnt), 32'h0);

    // Toggling segments never accepted; steady 0x6D lands exactly 6 edges later
    for (int k = 0; k < 6; k++) begin
      hold(6'b000001, (k % 2 == 0) ? 8'h06 : 8'h5B, 2);
    end
    check_val("t2_toggle_val", 32'(bus.value[3:0]), 32'h1);
    bus.seg = 8'h6D;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("t2_edge5", 32'(bus.value[3:0]), 32'h1);
    @(posedge clk);
    @(negedge clk);
    check_val("t2_edge6", 32'(bus.value[3:0]), 32'h5);
    @(posedge clk); #1;
    hold(6'd0, 8'h00, 2);

    // Multi-select then an unknown pattern
    hold(6'b000011, 8'h06, 8);
    check_val("t3_multi_err",   32'(bus.err_cnt), 32'd1);
    check_val("t3_multi_value", 32'(bus.value), 32'h654325);
    check_val("t3_multi_valid", 32'(bus.valid), 32'h3F);
    hold(6'd0, 8'h00, 2);
    hold(6'b000100, 8'h49, 8);
    check_val("t3_bad_err",   32'(bus.err_cnt), 32'd2);
    check_val("t3_bad_valid", 32'(bus.valid), 32'h3B);
    check_val("t3_bad_value", 32'(bus.value), 32'h654325);
    hold(6'd0, 8'h00, 2);

    // Asynchronous reset clears the error count mid-cycle
    rst = 1'b1;
    #2;
    check_val("t4_async_err", 32'(bus.err_cnt), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Blank digit then digit with decimal point
    hold(6'b001000, 8'h00, 8);
    hold(6'd0, 8'h00, 2);
    hold(6'b010000, 8'h86, 8);
    hold(6'd0, 8'h00, 2);
    check_val("t4_valid", 32'(bus.valid), 32'h10);
    check_val("t4_err",   32'(bus.err_cnt), 32'h0);
    check_val("t4_value", 32'(bus.value), 32'h010000);
    check_val("t4_dp",    32'(bus.dp), 32'h10);

    // Full frame "AbCdEF", then idle into stale
    fd_base = fd_cnt;
    scan(0, 8'h77); scan(1, 8'h7C); scan(2, 8'h39); scan(3, 8'h5E); scan(4, 8'h79); scan(5, 8'h71);
    check_val("t5_fd",    32'(fd_cnt - fd_base), 32'd1);
    check_val("t5_value", 32'(bus.value), 32'hFEDCBA);
    check_val("t5_valid", 32'(bus.valid), 32'h3F);
    // 4 edges already elapsed since the last digit accept
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_val("t5_not_stale", 32'(bus.stale), 32'h0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_val("t5_stale",       32'(bus.stale), 32'h1);
    check_val("t5_stale_valid", 32'(bus.valid), 32'h0);
    check_val("t5_stale_dp",    32'(bus.dp), 32'h0);
    check_val("t5_stale_value", 32'(bus.value), 32'hFEDCBA);
    @(posedge clk); #1;
    hold(6'b000100, 8'h4F, 8);
    check_val("t5_recover_stale", 32'(bus.stale), 32'h0);
    check_val("t5_recover_valid", 32'(bus.valid), 32'h04);
    check_val("t5_recover_value", 32'(bus.value), 32'hFED3BA);
    hold(6'd0, 8'h00, 2);

    // Reset mid-frame aborts it; a fresh 6 digits are needed
    scan(0, 8'h06); scan(1, 8'h5B); scan(2, 8'h4F);
    rst = 1'b1;
    #2;
    check_val("t6_rst_valid", 32'(bus.valid), 32'h0);
    check_val("t6_rst_value", 32'(bus.value), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    fd_base = fd_cnt;
    scan(0, 8'h06); scan(1, 8'h5B); scan(2, 8'h4F); scan(3, 8'h66); scan(4, 8'h6D);
    check_val("t6_fd_early", 32'(fd_cnt - fd_base), 32'd0);
    scan(5, 8'h7D);
    check_val("t6_fd",    32'(fd_cnt - fd_base), 32'd1);
    check_val("t6_value", 32'(bus.value), 32'h654321);
    check_val("t6_valid", 32'(bus.valid), 32'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Passive monitor for the multiplexed 6-digit 7-segment display bus driven by the board's display logic. It samples the `digit` and `seg` lines, filters scan transitions, and decodes each stable digit pattern back to a hex nibble plus decimal point. It publishes a per-digit value/valid image, a frame-complete pulse, error counts and a stale indication. It sits beside the display driver and feeds self-check logic and the register readback path.

## Interface
- `STABLE_CYC`, 4: consecutive synchronized cycles a `{digit,seg}` sample must hold before acceptance (≥2).
- `TIMEOUT_CYC`, 1_000_000: cycles with no acceptance before the image is declared stale.
- `DIGIT_ACT_LOW`, 0: 1 = `digit` lines are active-low.
- `SEG_ACT_LOW`, 0: 1 = `seg` lines are active-low (common-anode).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `digit`  in  6  digit select; bit n selects digit n.
- `seg`  in  8  segments `{dp,g,f,e,d,c,b,a}`; bit0 = a.
- `value`  out  24  decoded nibbles; digit n at `[4n+3:4n]`.
- `dp`  out  6  decimal point per digit.
- `valid`  out  6  digit n holds a decoded hex value.
- `frame_done`  out  1  one-cycle pulse when all 6 digits have been accepted since the last pulse.
- `stale`  out  1  high after `TIMEOUT_CYC` idle cycles.
- `err_cnt`  out  8  saturating count of bad patterns and multi-select events.

## Operation
- Polarity is normalized at the input. Both buses pass a 2-flop synchronizer to give the synchronized `s_digit`/`s_seg`.
- Stability counter `cnt`:
  - Resets to 0 when the synchronized sample differs from the previous cycle's.
  - Otherwise increments, saturating at `STABLE_CYC`.
- Acceptance:
  - `accept` fires exactly once per stable period, in the cycle where `cnt` reaches `STABLE_CYC-1`.
  - A sample that changes earlier is discarded.
- On `accept`, classify `s_digit`:
  - Zero bits set: blanking interval. Ignored, with no error and no timeout restart.
  - More than one bit set: `err_cnt`+1. No image update.
  - One-hot, digit n: decode `s_seg[6:0]`.
- Decode table (gfedcba → nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
- Decode outcomes:
  - Match: `value[n]` = nibble, `valid[n]`=1.
  - Pattern 00 (blank digit): `valid[n]`=0, `value[n]` unchanged, no error.
  - Any other pattern: `valid[n]`=0, `err_cnt`+1.
  - In all three cases `dp[n]`=`s_seg[7]` and `seen[n]`=1.
- Frame mask `seen`:
  - When an accepted update makes `seen`==6'h3F, pulse `frame_done` and clear `seen` to 0 in that same edge.
  - A repeated digit before the frame completes only overwrites that digit's value.
- Idle timer:
  - Counts cycles since the last one-hot or multi-select accept.
  - At `TIMEOUT_CYC` it sets `stale`=1 and clears `valid`, `seen` and `dp`. `value` is retained.
  - The next one-hot accept clears `stale` and the timer.
- `err_cnt` saturates at 255 and is cleared only by reset.

## Timing
- Reset values: `value`=0, `dp`=0, `valid`=0, `frame_done`=0, `stale`=0, `err_cnt`=0, `seen`=0, `cnt`=0, timer=0, synchronizers=0 (normalized).
- Latency:
  - A raw input change held steady updates the outputs at edge 2+`STABLE_CYC` after the first edge sampling it. For `STABLE_CYC`=4 that is 6 edges.
  - `frame_done` is coincident with the completing digit's `value`/`valid` update.
- A held sample is never re-accepted. Rescanning the same digit needs an intervening change; the blanking interval qualifies.
- Timeout and accept in the same cycle: accept wins. `stale` stays 0 and the timer restarts.
- Asynchronous `rst` mid-frame aborts the frame. The next `frame_done` requires 6 fresh digits.

## Structure
- Package `seg_pkg`: `SEG_*` pattern constants for 0–F and blank, `NUM_DIGITS`=6, and function `seg7_to_hex` returning `{ok,blank,nibble}`.
- Sub-module `seg_in_filter`: polarity normalize, 2-flop sync, stability counter, `accept` strobe. The top holds the image, frame mask, timer and error counter.

## Test plan
- Scan 0–5 showing "123456", one-hot, 8 cycles each with 2-cycle blanking → `value`=24'h654321, `valid`=3F, one `frame_done` after digit 5.
- `digit`=6'b000001 with `seg` toggling every 2 cycles (`STABLE_CYC`=4), then steady at 0x6D → no update during toggling; `value[3:0]`=5 exactly 6 edges after the steady value starts.
- `digit`=6'b000011 held, then digit 2 with `seg`=0x49 → `err_cnt`=2, `valid[2]`=0, no image change for the multi-select.
- Digit 3 with `seg`=0x00, then digit 4 with `seg`=0x86 → `valid[3]`=0, `err_cnt`=0; `value[19:16]`=1, `dp[4]`=1.
- Full frame, then inputs idle for `TIMEOUT_CYC` (set to 50) → `stale`=1 at cycle 50, `valid`=0, `value` retained; the next digit clears `stale`.
- Assert `rst` after 3 digits accepted, then scan 6 digits → `frame_done` only after all 6 post-reset digits.
